// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard for the pipelined WISC core.
// Tracks in-flight register writers for DEPTH stages after decode. From those
// entries it produces the load-use stall and the per-operand forward selects.
// Optional build macro: HAZARD_SCOREBOARD_ZERO_REG_EN hardwires register 0, so
// it is never matched as a source and never tracked as a destination.
module hazard_scoreboard #(
   parameter int unsigned NUM_REGS   = 8,
   parameter int unsigned REG_W      = 3,
   parameter int unsigned DEPTH      = 3,
   parameter int unsigned LOAD_READY = 2,
   parameter int unsigned FW         = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   input  logic [REG_W-1:0] issue_rs,
   input  logic             issue_rs_used,
   input  logic [REG_W-1:0] issue_rt,
   input  logic             issue_rt_used,
   input  logic             issue_wr_en,
   input  logic [REG_W-1:0] issue_rd,
   input  logic             issue_is_load,
   input  logic             flush,
   output logic             stall,
   output logic [FW-1:0]    fwd_a,
   output logic [FW-1:0]    fwd_b,
   output logic [15:0]      stall_count,
   output logic             err
);

   // Entry index k holds the writer currently in stage k+1.
   logic [DEPTH-1:0] ent_valid_q;
   logic [DEPTH-1:0] ent_load_q;
   logic [REG_W-1:0] ent_rd_q [DEPTH];

   logic use_a, use_b, wr_ok;
   logic early_a, early_b;
   logic err_d;

`ifdef HAZARD_SCOREBOARD_ZERO_REG_EN
   assign use_a = issue_valid & issue_rs_used & (issue_rs != '0);
   assign use_b = issue_valid & issue_rt_used & (issue_rt != '0);
   assign wr_ok = issue_wr_en & (issue_rd != '0);
`else
   assign use_a = issue_valid & issue_rs_used;
   assign use_b = issue_valid & issue_rt_used;
   assign wr_ok = issue_wr_en;
`endif

   // Youngest-writer match per source: scan oldest to youngest so the lowest stage wins.
   always_comb begin
      fwd_a   = '0;
      fwd_b   = '0;
      early_a = 1'b0;
      early_b = 1'b0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (use_a && ent_valid_q[i] && (ent_rd_q[i] == issue_rs)) begin
            fwd_a   = FW'(i + 1);
            early_a = ent_load_q[i] && ((i + 1) < int'(LOAD_READY));
         end
         if (use_b && ent_valid_q[i] && (ent_rd_q[i] == issue_rt)) begin
            fwd_b   = FW'(i + 1);
            early_b = ent_load_q[i] && ((i + 1) < int'(LOAD_READY));
         end
      end
   end

   // Flush overrides the load-use stall; the squashed instruction becomes a bubble anyway.
   assign stall = issue_valid & ~flush & (early_a | early_b);

   // Out-of-range register indices flag a decode or configuration fault.
   always_comb begin
      err_d = err;
      if (issue_valid) begin
         if (issue_wr_en && (32'(issue_rd) >= NUM_REGS)) err_d = 1'b1;
         if (issue_rs_used && (32'(issue_rs) >= NUM_REGS)) err_d = 1'b1;
         if (issue_rt_used && (32'(issue_rt) >= NUM_REGS)) err_d = 1'b1;
      end
   end

   // Shift writers one stage per cycle; a stalled or flushed decode inserts a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         ent_valid_q <= '0;
         ent_load_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) ent_rd_q[i] <= '0;
      end else begin
         for (int i = int'(DEPTH) - 1; i > 0; i--) begin
            ent_valid_q[i] <= ent_valid_q[i-1];
            ent_load_q[i]  <= ent_load_q[i-1];
            ent_rd_q[i]    <= ent_rd_q[i-1];
         end
         ent_valid_q[0] <= issue_valid & wr_ok & ~stall & ~flush;
         ent_load_q[0]  <= issue_is_load;
         ent_rd_q[0]    <= issue_rd;
      end
   end

   // Saturating stall counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
         err         <= 1'b0;
      end else begin
         if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
         err <= err_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard. Three instances share stimulus:
// defaults, LOAD_READY = 3, and NUM_REGS = 6. Each expectation names the
// instance it targets; a monitor compares on the falling clock edge.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       issue_valid, issue_rs_used, issue_rt_used, issue_wr_en, issue_is_load, flush;
   logic [2:0] issue_rs, issue_rt, issue_rd;

   logic       stall0, stall1, stall2;
   logic [1:0] fa0, fb0, fa1, fb1, fa2, fb2;
   logic [15:0] cnt0, cnt1, cnt2;
   logic       err0, err1, err2;

   always #5 clk = ~clk;

   hazard_scoreboard u_def (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs(issue_rs),
      .issue_rs_used(issue_rs_used), .issue_rt(issue_rt), .issue_rt_used(issue_rt_used),
      .issue_wr_en(issue_wr_en), .issue_rd(issue_rd), .issue_is_load(issue_is_load),
      .flush(flush), .stall(stall0), .fwd_a(fa0), .fwd_b(fb0), .stall_count(cnt0), .err(err0)
   );

   hazard_scoreboard #(.LOAD_READY(3)) u_lr3 (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs(issue_rs),
      .issue_rs_used(issue_rs_used), .issue_rt(issue_rt), .issue_rt_used(issue_rt_used),
      .issue_wr_en(issue_wr_en), .issue_rd(issue_rd), .issue_is_load(issue_is_load),
      .flush(flush), .stall(stall1), .fwd_a(fa1), .fwd_b(fb1), .stall_count(cnt1), .err(err1)
   );

   hazard_scoreboard #(.NUM_REGS(6)) u_nr6 (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs(issue_rs),
      .issue_rs_used(issue_rs_used), .issue_rt(issue_rt), .issue_rt_used(issue_rt_used),
      .issue_wr_en(issue_wr_en), .issue_rd(issue_rd), .issue_is_load(issue_is_load),
      .flush(flush), .stall(stall2), .fwd_a(fa2), .fwd_b(fb2), .stall_count(cnt2), .err(err2)
   );

   typedef struct {
      string       name;
      int          sel;
      logic        stall;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        chk_cnt;
      logic [15:0] cnt;
      logic        chk_err;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input logic [2:0] rs, input logic rsu,
                        input logic [2:0] rt, input logic rtu, input logic we,
                        input logic [2:0] rd, input logic ld, input logic fl);
      issue_valid   = v;
      issue_rs      = rs;
      issue_rs_used = rsu;
      issue_rt      = rt;
      issue_rt_used = rtu;
      issue_wr_en   = we;
      issue_rd      = rd;
      issue_is_load = ld;
      flush         = fl;
   endtask

   task automatic expect_out(input string n, input int sel, input logic st,
                             input logic [1:0] a, input logic [1:0] b,
                             input logic cc, input logic [15:0] c,
                             input logic ce, input logic e);
      exp_t x;
      x.name = n; x.sel = sel; x.stall = st; x.fa = a; x.fb = b;
      x.chk_cnt = cc; x.cnt = c; x.chk_err = ce; x.err = e;
      exp_q.push_back(x);
   endtask

   // Monitor: pop every expectation queued this cycle and compare against its instance.
   always @(negedge clk) begin
      exp_t        x;
      logic        st, er;
      logic [1:0]  a, b;
      logic [15:0] c;
      while (exp_q.size() != 0) begin
         x = exp_q.pop_front();
         case (x.sel)
            1:       begin st = stall1; a = fa1; b = fb1; c = cnt1; er = err1; end
            2:       begin st = stall2; a = fa2; b = fb2; c = cnt2; er = err2; end
            default: begin st = stall0; a = fa0; b = fb0; c = cnt0; er = err0; end
         endcase
         vectors++;
         if (st !== x.stall) begin
            miscompares++;
            $display("FAIL %s stall: got %b want %b", x.name, st, x.stall);
         end
         if (a !== x.fa) begin
            miscompares++;
            $display("FAIL %s fwd_a: got %0d want %0d", x.name, a, x.fa);
         end
         if (b !== x.fb) begin
            miscompares++;
            $display("FAIL %s fwd_b: got %0d want %0d", x.name, b, x.fb);
         end
         if (x.chk_cnt && (c !== x.cnt)) begin
            miscompares++;
            $display("FAIL %s stall_count: got %0d want %0d", x.name, c, x.cnt);
         end
         if (x.chk_err && (er !== x.err)) begin
            miscompares++;
            $display("FAIL %s err: got %b want %b", x.name, er, x.err);
         end
      end
   end

   initial begin
      rst = 1'b1;
      issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      rst = 1'b0;

      // First cycle out of reset: no writers tracked.
      issue(1, 3, 1, 2, 1, 0, 0, 0, 0);
      expect_out("reset_state", 0, 0, 0, 0, 1, 0, 1, 0);

      // ALU writer r3, then consumers at distances 1..4.
      step(); issue(1, 1, 1, 2, 1, 1, 3, 0, 0);
      expect_out("add_issue", 0, 0, 0, 0, 0, 0, 0, 0);
      step(); issue(1, 3, 1, 0, 0, 0, 0, 0, 0);
      expect_out("fwd_ex", 0, 0, 1, 0, 0, 0, 0, 0);
      step(); expect_out("fwd_mem", 0, 0, 2, 0, 0, 0, 0, 0);
      step(); expect_out("fwd_wb", 0, 0, 3, 0, 0, 0, 0, 0);
      step(); expect_out("fwd_rf", 0, 0, 0, 0, 0, 0, 0, 0);

      // Load-use on rt: one stall cycle, then forward from MEM.
      step(); issue(1, 0, 0, 0, 0, 1, 2, 1, 0);
      expect_out("ld_issue", 0, 0, 0, 0, 0, 0, 0, 0);
      step(); issue(1, 1, 1, 2, 1, 0, 0, 0, 0);
      expect_out("lu_stall", 0, 1, 0, 1, 1, 0, 0, 0);
      step(); expect_out("lu_fwd", 0, 0, 0, 2, 1, 1, 0, 0);
      step(); issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("lu_count", 0, 0, 0, 0, 1, 1, 0, 0);

      // Flush beats a load-use stall and its writer (r6) becomes a bubble.
      step(); issue(1, 0, 0, 0, 0, 1, 4, 1, 0);
      expect_out("ld_r4", 0, 0, 0, 0, 0, 0, 0, 0);
      step(); issue(1, 4, 1, 0, 0, 1, 6, 0, 1);
      expect_out("flush", 0, 0, 1, 0, 1, 1, 0, 0);
      step(); issue(1, 6, 1, 4, 1, 0, 0, 0, 0);
      expect_out("flush_bubble", 0, 0, 0, 2, 1, 1, 0, 0);

      // Fill with three writers, then reset mid-operation.
      step(); issue(1, 0, 0, 0, 0, 1, 1, 0, 0);
      step(); issue(1, 0, 0, 0, 0, 1, 2, 0, 0);
      step(); issue(1, 1, 1, 2, 1, 1, 3, 0, 0);
      expect_out("full", 0, 0, 2, 1, 1, 1, 0, 0);
      step(); rst = 1'b1; issue(1, 3, 1, 2, 1, 0, 0, 0, 0);
      step(); rst = 1'b0;
      expect_out("mid_reset", 0, 0, 0, 0, 1, 0, 1, 0);

      // LOAD_READY = 3: two stall cycles, then forward from WB.
      step(); issue(1, 0, 0, 0, 0, 1, 5, 1, 0);
      expect_out("lr3_ld", 1, 0, 0, 0, 0, 0, 0, 0);
      step(); issue(1, 5, 1, 0, 0, 0, 0, 0, 0);
      expect_out("lr3_stall1", 1, 1, 1, 0, 0, 0, 0, 0);
      step(); expect_out("lr3_stall2", 1, 1, 2, 0, 0, 0, 0, 0);
      step(); expect_out("lr3_fwd", 1, 0, 3, 0, 1, 2, 0, 0);

      // Two writers of r4 in flight: the youngest wins.
      step(); issue(1, 0, 0, 0, 0, 1, 4, 0, 0);
      step();
      step(); issue(1, 4, 1, 0, 0, 0, 0, 0, 0);
      expect_out("youngest", 1, 0, 1, 0, 0, 0, 0, 0);

      // NUM_REGS = 6: writing r7 sets a sticky error, cleared only by reset.
      step(); issue(1, 0, 0, 0, 0, 1, 7, 0, 0);
      expect_out("err_pre", 2, 0, 0, 0, 0, 0, 1, 0);
      step(); issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("err_set", 2, 0, 0, 0, 0, 0, 1, 1);
      step(); expect_out("err_hold", 2, 0, 0, 0, 0, 0, 1, 1);
      expect_out("err_inrange", 0, 0, 0, 0, 0, 0, 1, 0);
      step(); rst = 1'b1;
      step(); rst = 1'b0;
      expect_out("err_clear", 2, 0, 0, 0, 1, 0, 1, 0);

      // Register 0: hardwired only when the zero-register build option is on.
      step(); issue(1, 0, 0, 0, 0, 1, 0, 1, 0);
      expect_out("ld_r0", 0, 0, 0, 0, 0, 0, 0, 0);
      step(); issue(1, 0, 1, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_SCOREBOARD_ZERO_REG_EN
      expect_out("zero_reg", 0, 0, 0, 0, 0, 0, 0, 0);
`else
      expect_out("zero_reg", 0, 1, 1, 0, 0, 0, 0, 0);
`endif
      step(); issue(0, 0, 1, 0, 0, 0, 0, 0, 0);
      expect_out("no_valid", 0, 0, 0, 0, 0, 0, 0, 0);
      step(); issue(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Bounded drain of any outstanding expectations.
      for (int i = 0; i < 4 && exp_q.size() != 0; i++) step();
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
